rv32i_encoder: RTL
==================

Name: rv32i_encoder

Overview:
- Builds RV32I instruction words from field-level requests; the inverse of the core's instruction decoder.
- Feeds the debug program buffer and the self-test instruction injector ahead of the fetch mux.
- Checks field ranges and expands the LI pseudo-op into a LUI/ADDI pair when needed.
- Uses a valid/ready interface on both sides, with one registered output slot.

Parameters:
- None. XLEN is fixed at 32.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted on a cycle where req_valid_i && req_ready_o
- req_op_i  in  4  RV_ENCOP_* operation class
- req_rd_i, req_rs1_i, req_rs2_i  in  5 each  register fields
- req_funct3_i  in  3  minor opcode, or CSR funct3 for CSR ops
- req_alt_i  in  1  selects SUB/SRA (funct7 = 0100000)
- req_imm_i  in  32  byte offset, immediate, CSR address (bits 11:0) or zimm
- ins_valid_o  out  1  output word valid
- ins_ready_i  in  1  downstream accepts the word
- ins_o  out  32  encoded instruction
- err_o  out  1  one-cycle pulse: the request accepted last cycle was rejected
- busy_o  out  1  FSM is not in S_IDLE, or ins_valid_o is high

Behaviour:
- Reset values:
  - ins_valid_o = 0, ins_o = 0, err_o = 0.
  - FSM in S_IDLE.
  - req_ready_o = 1 after reset.
- Ready rule: req_ready_o = (state == S_IDLE) && (!ins_valid_o || ins_ready_i).
- Latency: a request accepted in cycle N produces ins_valid_o (or err_o) in cycle N+1.
- Output hold: while ins_valid_o && !ins_ready_i, ins_o holds stable. A new word loads on the same edge the old one is taken.
- Supported ops and encodings:
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCEI, ECALL, WFI, CSR, CSRI, LI.
  - Standard RV32I encodings; CSR address comes from imm[11:0].
  - FENCEI = 0x0000100F, ECALL = 0x00000073, WFI = 0x10500073.
- Error checks. Any failure means no word is emitted, err_o pulses in N+1, and the request is consumed.
  - I and S immediates must lie in [-2048, 2047].
  - SB immediates must be even, in [-4096, 4094].
  - UJ immediates must be even, in [-2^20, 2^20-2].
  - LUI/AUIPC: imm[11:0] must be 0; the word takes imm[31:12].
  - Shifts: imm[31:5] must be 0.
  - BRANCH funct3 must be one of {0,1,4,5,6,7}.
  - LOAD funct3 must be one of {0,1,2,4,5}.
  - STORE funct3 must be one of {0,1,2}.
  - OP/OPIMM: req_alt_i is legal only with funct3 0 (OP only) or 5.
  - CSR funct3 must be one of {1,2,3}; CSRI funct3 must be one of {5,6,7}.
  - An unknown op code is an error.
- LI rd, imm:
  - If imm is in [-2048, 2047]: emit one word, ADDI rd, x0, imm.
  - Otherwise: hi = (imm + 0x800) >> 12 (mod 2^20), lo = sign_extend(imm[11:0]).
  - Emit LUI rd, hi. If lo != 0, the FSM enters S_EXPAND holding ADDI rd, rd, lo.
- FSM:
  - S_IDLE -> S_EXPAND on accepting an LI that needs two words with lo != 0.
  - S_EXPAND: when ins_valid_o && ins_ready_i, load the ADDI word and return to S_IDLE.
  - req_ready_o stays 0 throughout S_EXPAND.
- Reset at any cycle, including S_EXPAND or a held output: the pending word is dropped, ins_valid_o = 0, the FSM returns to S_IDLE, err_o = 0.
- Downstream stall on the LUI: the ADDI word waits. Words always leave strictly in order.

Optional Feature:
- RV_ENCODER_PSEUDO_EN.
- Defined: LI is supported as above, with the S_EXPAND state.
- Undefined: the S_EXPAND state is not built. RV_ENCOP_LI is treated as an unknown op (err_o pulses), and busy_o = ins_valid_o.

Decomposition:
- Shared constants in riscv_defs.v:
  - RV_ENCOP_* op codes (4-bit) and RV_ENCOP_RANGE.
  - Major opcode constants (RV_OPCODE_LUI, and so on).
  - The existing RV_MINOR_OPCODE_* values are reused.
- One combinational sub-module, rv32i_encode_word:
  - Inputs: op/fields.
  - Outputs: word, err, needs_second, second_word.
- rv32i_encoder keeps only the registers, FSM and handshake logic.

Test Plan:
1. OPIMM ADDI rd=1, rs1=2, imm=-1 -> ins_o = 0xFFF10093 in cycle N+1, err_o = 0.
2. LI rd=5, imm=0x12345678 -> 0x123452B7, then 0x67828293 in consecutive cycles; req_ready_o = 0 between them. LI rd=5, imm=0x800 -> 0x000012B7, then 0x80028293. LI rd=5, imm=0x5000 -> single word 0x000052B7.
3. BRANCH funct3=0, imm=3 -> err_o pulse, no ins_valid_o. JAL imm=0x00100000 -> err_o pulse.
4. Backpressure: hold ins_ready_i = 0 for 3 cycles with ins_o = 0x123452B7 -> word stable, req_ready_o = 0, and ADDI is emitted only after the handshake.
5. Reset asserted in S_EXPAND after the LUI is taken -> no ADDI is emitted, ins_valid_o = 0, req_ready_o = 1 on the cycle after reset deasserts.
6. RV_ENCODER_PSEUDO_EN undefined: LI request -> err_o pulse, no word emitted.

Source files
------------

// File: rtl/rv32i_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Optional LI expansion is controlled by the RV_ENCODER_PSEUDO_EN macro.
package rv32i_encoder_pkg;

    // Request operation classes presented on req_op_i
    typedef enum logic [3:0] {
        RV_ENCOP_LUI    = 4'd0,
        RV_ENCOP_AUIPC  = 4'd1,
        RV_ENCOP_JAL    = 4'd2,
        RV_ENCOP_JALR   = 4'd3,
        RV_ENCOP_BRANCH = 4'd4,
        RV_ENCOP_LOAD   = 4'd5,
        RV_ENCOP_STORE  = 4'd6,
        RV_ENCOP_OPIMM  = 4'd7,
        RV_ENCOP_OP     = 4'd8,
        RV_ENCOP_FENCEI = 4'd9,
        RV_ENCOP_ECALL  = 4'd10,
        RV_ENCOP_WFI    = 4'd11,
        RV_ENCOP_CSR    = 4'd12,
        RV_ENCOP_CSRI   = 4'd13,
        RV_ENCOP_LI     = 4'd14
    } enc_op_e;

    localparam int unsigned RV_ENCOP_RANGE = 15;

    // Major opcodes
    localparam logic [6:0] RV_OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] RV_OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] RV_OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] RV_OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] RV_OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] RV_OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] RV_OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] RV_OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] RV_OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] RV_OPCODE_SYSTEM = 7'b1110011;

    // Minor opcodes used by the encoder
    localparam logic [2:0] RV_MINOR_OPCODE_ADDI      = 3'b000;
    localparam logic [2:0] RV_MINOR_OPCODE_SLLI      = 3'b001;
    localparam logic [2:0] RV_MINOR_OPCODE_SRLI_SRAI = 3'b101;
    localparam logic [6:0] RV_FUNCT7_ALT             = 7'b0100000;

    // Fixed instruction words
    localparam logic [31:0] RV_INS_FENCEI = 32'h0000100F;
    localparam logic [31:0] RV_INS_ECALL  = 32'h00000073;
    localparam logic [31:0] RV_INS_WFI    = 32'h10500073;

`ifdef RV_ENCODER_PSEUDO_EN
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } enc_state_e;
`endif

    // True when v is representable as a signed value of the given width
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] w_top;
        w_top = $signed(v) >>> (bits - 1);
        return (w_top == '0) || (w_top == '1);
    endfunction

endpackage

// File: rtl/rv32i_encode_word.sv
// Combinational RV32I word builder with field range checks.
// With RV_ENCODER_PSEUDO_EN defined, LI is expanded into LUI (+ ADDI).
module rv32i_encode_word
    import rv32i_encoder_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic        i_alt,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_err
`ifdef RV_ENCODER_PSEUDO_EN
    ,
    output logic        o_needs_second,
    output logic [31:0] o_second_word
`endif
);

    logic        w_fits_i;
    logic        w_fits_b;
    logic        w_fits_j;
    logic        w_shift;
    logic [6:0]  w_funct7;
    logic [31:0] w_i_word;

    assign w_fits_i = fits_signed(i_imm, 12);
    assign w_fits_b = fits_signed(i_imm, 13) && !i_imm[0];
    assign w_fits_j = fits_signed(i_imm, 21) && !i_imm[0];
    assign w_shift  = (i_funct3 == RV_MINOR_OPCODE_SLLI) || (i_funct3 == RV_MINOR_OPCODE_SRLI_SRAI);
    assign w_funct7 = i_alt ? RV_FUNCT7_ALT : '0;
    assign w_i_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, 7'b0};

`ifdef RV_ENCODER_PSEUDO_EN
    // Rounding by +0x800 makes the sign-extended low 12 bits add back correctly
    logic [31:0] w_li_hi;
    assign w_li_hi = i_imm + 32'h0000_0800;
`endif

    // Select encoding format and legality check by operation class
    always_comb begin
        o_word = '0;
        o_err  = 1'b0;
`ifdef RV_ENCODER_PSEUDO_EN
        o_needs_second = 1'b0;
        o_second_word  = '0;
`endif
        case (i_op)
            RV_ENCOP_LUI: begin
                o_err  = (i_imm[11:0] != '0);
                o_word = {i_imm[31:12], i_rd, RV_OPCODE_LUI};
            end
            RV_ENCOP_AUIPC: begin
                o_err  = (i_imm[11:0] != '0);
                o_word = {i_imm[31:12], i_rd, RV_OPCODE_AUIPC};
            end
            RV_ENCOP_JAL: begin
                o_err  = !w_fits_j;
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, RV_OPCODE_JAL};
            end
            RV_ENCOP_JALR: begin
                o_err  = !w_fits_i;
                o_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, RV_OPCODE_JALR};
            end
            RV_ENCOP_BRANCH: begin
                o_err  = !w_fits_b || (i_funct3[2:1] == 2'b01);
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], RV_OPCODE_BRANCH};
            end
            RV_ENCOP_LOAD: begin
                o_err  = !w_fits_i || (i_funct3 == 3'd3) || (i_funct3[2:1] == 2'b11);
                o_word = w_i_word | {25'b0, RV_OPCODE_LOAD};
            end
            RV_ENCOP_STORE: begin
                o_err  = !w_fits_i || (i_funct3 > 3'd2);
                o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], RV_OPCODE_STORE};
            end
            RV_ENCOP_OPIMM: begin
                if (w_shift) begin
                    o_err  = (i_imm[31:5] != '0) ||
                             (i_alt && (i_funct3 != RV_MINOR_OPCODE_SRLI_SRAI));
                    o_word = {w_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, RV_OPCODE_OPIMM};
                end else begin
                    o_err  = !w_fits_i || i_alt;
                    o_word = w_i_word | {25'b0, RV_OPCODE_OPIMM};
                end
            end
            RV_ENCOP_OP: begin
                o_err  = i_alt && (i_funct3 != 3'd0) && (i_funct3 != 3'd5);
                o_word = {w_funct7, i_rs2, i_rs1, i_funct3, i_rd, RV_OPCODE_OP};
            end
            RV_ENCOP_FENCEI: o_word = RV_INS_FENCEI;
            RV_ENCOP_ECALL:  o_word = RV_INS_ECALL;
            RV_ENCOP_WFI:    o_word = RV_INS_WFI;
            RV_ENCOP_CSR: begin
                o_err  = (i_funct3 == 3'd0) || i_funct3[2];
                o_word = w_i_word | {25'b0, RV_OPCODE_SYSTEM};
            end
            // The 5-bit zimm travels in the rs1 field; imm[11:0] stays the CSR address
            RV_ENCOP_CSRI: begin
                o_err  = !i_funct3[2] || (i_funct3[1:0] == 2'b00);
                o_word = w_i_word | {25'b0, RV_OPCODE_SYSTEM};
            end
`ifdef RV_ENCODER_PSEUDO_EN
            RV_ENCOP_LI: begin
                if (w_fits_i) begin
                    o_word = {i_imm[11:0], 5'd0, RV_MINOR_OPCODE_ADDI, i_rd, RV_OPCODE_OPIMM};
                end else begin
                    o_word         = {w_li_hi[31:12], i_rd, RV_OPCODE_LUI};
                    o_needs_second = (i_imm[11:0] != '0);
                    o_second_word  = {i_imm[11:0], i_rd, RV_MINOR_OPCODE_ADDI, i_rd, RV_OPCODE_OPIMM};
                end
            end
`endif
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_encoder.sv
// RV32I instruction encoder: valid/ready request in, one registered word out.
// RV_ENCODER_PSEUDO_EN adds the S_EXPAND state for two-word LI sequences.
module rv32i_encoder
    import rv32i_encoder_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_op_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [2:0]  req_funct3_i,
    input  logic        req_alt_i,
    input  logic [31:0] req_imm_i,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic [31:0] ins_o,
    output logic        err_o,
    output logic        busy_o
);

    logic [31:0] w_word;
    logic        w_err;
    logic        w_accept;
    logic        r_ins_valid;
    logic [31:0] r_ins;
    logic        r_err;
    logic        w_ins_valid_nxt;
    logic [31:0] w_ins_nxt;
    logic        w_err_nxt;

`ifdef RV_ENCODER_PSEUDO_EN
    logic        w_needs_second;
    logic [31:0] w_second_word;
    logic        w_take;
    enc_state_e  r_state;
    enc_state_e  w_state_nxt;
    logic [31:0] r_pending;
    logic [31:0] w_pending_nxt;
`endif

    rv32i_encode_word u_encode (
        .i_op          (req_op_i),
        .i_rd          (req_rd_i),
        .i_rs1         (req_rs1_i),
        .i_rs2         (req_rs2_i),
        .i_funct3      (req_funct3_i),
        .i_alt         (req_alt_i),
        .i_imm         (req_imm_i),
        .o_word        (w_word),
        .o_err         (w_err)
`ifdef RV_ENCODER_PSEUDO_EN
        ,
        .o_needs_second(w_needs_second),
        .o_second_word (w_second_word)
`endif
    );

`ifdef RV_ENCODER_PSEUDO_EN
    assign w_take      = r_ins_valid && ins_ready_i;
    assign req_ready_o = (r_state == S_IDLE) && (!r_ins_valid || ins_ready_i);
    assign busy_o      = (r_state != S_IDLE) || r_ins_valid;

    // FSM state and held second word
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end
`else
    assign req_ready_o = !r_ins_valid || ins_ready_i;
    assign busy_o      = r_ins_valid;
`endif

    assign w_accept    = req_valid_i && req_ready_o;
    assign ins_valid_o = r_ins_valid;
    assign ins_o       = r_ins;
    assign err_o       = r_err;

    // Next output slot, error pulse and FSM transition
    always_comb begin
        w_ins_valid_nxt = r_ins_valid && !ins_ready_i;
        w_ins_nxt       = r_ins;
        w_err_nxt       = 1'b0;
`ifdef RV_ENCODER_PSEUDO_EN
        w_state_nxt     = r_state;
        w_pending_nxt   = r_pending;
        // The ADDI replaces the LUI on the same edge the LUI is taken
        if ((r_state == S_EXPAND) && w_take) begin
            w_ins_nxt       = r_pending;
            w_ins_valid_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
        end
`endif
        if (w_accept) begin
            if (w_err) begin
                w_err_nxt = 1'b1;
            end else begin
                w_ins_nxt       = w_word;
                w_ins_valid_nxt = 1'b1;
`ifdef RV_ENCODER_PSEUDO_EN
                if (w_needs_second) begin
                    w_state_nxt   = S_EXPAND;
                    w_pending_nxt = w_second_word;
                end
`endif
            end
        end
    end

    // Registered output slot and error pulse
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ins_valid <= 1'b0;
            r_ins       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_ins_valid <= w_ins_valid_nxt;
            r_ins       <= w_ins_nxt;
            r_err       <= w_err_nxt;
        end
    end

endmodule
